// File: rtl/dac7624_pkg.sv
// Shared types, register addresses and the channel-priority helper for the DAC7624 sequencer.
// No logic of its own; no latency or backpressure.
package dac7624_pkg;

   typedef enum logic [2:0] {IDLE, SETUP, CS, HOLD, LDAC, RESET} state_t;
   typedef logic [1:0] dac_ch_t;

   localparam logic [7:0] ADDR_CH0    = 8'h10;
   localparam logic [7:0] ADDR_CH1    = 8'h11;
   localparam logic [7:0] ADDR_CH2    = 8'h12;
   localparam logic [7:0] ADDR_CH3    = 8'h13;
   localparam logic [7:0] ADDR_CTRL   = 8'h14;
   localparam logic [7:0] ADDR_RAMP   = 8'h15;
   localparam logic [7:0] ADDR_STATUS = 8'h16;

   // Lowest set index wins; callers only use the result when d != 0.
   function automatic dac_ch_t lowest_dirty(input logic [3:0] d);
      dac_ch_t n;
      n = 2'd3;
      for (int i = 3; i >= 0; i--) begin
         if (d[i]) n = dac_ch_t'(i);
      end
      return n;
   endfunction

endpackage

// File: rtl/dac7624_tmr.sv
// Loadable down-counter shared by every timed state of the sequencer.
// done is high in the last cycle of a LOAD-cycle interval starting in the cycle start is high.
// No backpressure; a new start restarts the interval.
module dac7624_tmr #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         nres,
   input  logic         start,
   input  logic [W-1:0] load,
   output logic         done
);

   logic [W-1:0] cnt;
   logic [W-1:0] rem;

   // rem = cycles still to spend, including the current one
   assign rem  = start ? load : cnt;
   assign done = (rem <= W'(1));

   always_ff @(posedge clk or negedge nres) begin
      if (!nres) cnt <= '0;
      else       cnt <= (rem != '0) ? rem - W'(1) : '0;
   end

endmodule

// File: rtl/dac7624_seq.sv
// DAC7624 sequencer: shadow regs -> timed nCS writes -> one nLDAC; ramp stepping under DAC_RAMP_EN.
// Host writes take effect next cycle; reads are registered with 1-cycle latency.
// No host backpressure: writes landing mid-batch re-dirty the channel and are folded into the same batch.
import dac7624_pkg::*;

module dac7624_seq #(
   parameter int CLK_FREQ     = 50000000,
   parameter int SETUP_CYCLES = 1,
   parameter int CS_CYCLES    = 3,
   parameter int HOLD_CYCLES  = 1,
   parameter int LDAC_CYCLES  = 3,
   parameter int RST_CYCLES   = 5
) (
   input  logic        clk,
   input  logic        nres,
   input  logic        we32,
   input  logic [7:0]  addr,
   input  logic [31:0] data_in32,
   output logic [31:0] data_out32,
   input  logic        startStep,
   output logic        READ,
   output logic        nCS,
   output logic        nRESET,
   output logic        nLDAC,
   output dac_ch_t     ch,
   output logic [11:0] data,
   output logic        busy,
   output logic        start_counter
);

   localparam logic [7:0] T_SETUP = 8'(SETUP_CYCLES);
   localparam logic [7:0] T_CS    = 8'(CS_CYCLES);
   localparam logic [7:0] T_HOLD  = 8'(HOLD_CYCLES);
   localparam logic [7:0] T_LDAC  = 8'(LDAC_CYCLES);
   localparam logic [7:0] T_RST   = 8'(RST_CYCLES);

   state_t      state;
   logic [11:0] shadow [4];
   logic [3:0]  dirty;
   logic        tmr_start, tmr_done;
   logic [7:0]  tmr_load;
   logic        ch_wr, ctrl_wr, srst, lat;
   dac_ch_t     nxt_ch;
   logic        ramp_en, overrun, step_ok, step_loaded;
   dac_ch_t     ramp_ch;
   logic [11:0] ramp_step, ramp_limit, ramp_val;
   logic [31:0] rd_val;

   assign READ    = 1'b0;
   assign ch_wr   = we32 && (addr[7:2] == ADDR_CH0[7:2]);
   assign ctrl_wr = we32 && (addr == ADDR_CTRL);
   assign srst    = ctrl_wr && data_in32[0];
   assign nxt_ch  = lowest_dirty(dirty);
   // IDLE holds off while the host is still writing channels so a burst forms one batch
   assign lat     = (dirty != 4'd0) && !srst &&
                    (((state == IDLE) && !ch_wr) || ((state == HOLD) && tmr_done));

`ifdef DAC_RAMP_EN
   logic        armed, ldac_exit, step_req, step_clash;
   dac_ch_t     step_ch;
   logic [12:0] ramp_sum;
   logic        unused_bits;

   assign ldac_exit  = (state == LDAC) && tmr_done && !srst;
   assign step_req   = startStep && ramp_en;
   assign step_clash = ch_wr && (addr[1:0] == ramp_ch);
   assign step_ok    = step_req && !armed && !step_clash && !srst;
   assign ramp_sum   = {1'b0, shadow[ramp_ch]} + {1'b0, ramp_step};
   assign ramp_val   = (ramp_sum > {1'b0, ramp_limit}) ? ramp_limit : ramp_sum[11:0];
   assign unused_bits = ^{32'(CLK_FREQ), data_in32[31:28], data_in32[15:12]};

   always_ff @(posedge clk or negedge nres) begin
      if (!nres) begin
         ramp_en     <= 1'b0;
         ramp_ch     <= '0;
         ramp_step   <= '0;
         ramp_limit  <= '0;
         overrun     <= 1'b0;
         armed       <= 1'b0;
         step_loaded <= 1'b0;
         step_ch     <= '0;
      end else begin
         if (ctrl_wr) begin
            ramp_en <= data_in32[2];
            ramp_ch <= data_in32[5:4];
            if (data_in32[3]) overrun <= 1'b0;
         end
         if (we32 && (addr == ADDR_RAMP)) begin
            ramp_step  <= data_in32[11:0];
            ramp_limit <= data_in32[27:16];
         end
         if (srst) begin
            armed       <= 1'b0;
            step_loaded <= 1'b0;
         end else begin
            if (step_req && (armed || step_clash)) overrun <= 1'b1;
            if (step_ok) begin
               armed   <= 1'b1;
               step_ch <= ramp_ch;
            end
            // the step counts as loaded once its channel is latched into a write cycle
            if (lat && armed && (nxt_ch == step_ch)) step_loaded <= 1'b1;
            if (ldac_exit && step_loaded) begin
               armed       <= 1'b0;
               step_loaded <= 1'b0;
            end
         end
      end
   end
`else
   logic unused_bits;

   assign ramp_en     = 1'b0;
   assign ramp_ch     = '0;
   assign ramp_step   = '0;
   assign ramp_limit  = '0;
   assign ramp_val    = '0;
   assign overrun     = 1'b0;
   assign step_ok     = 1'b0;
   assign step_loaded = 1'b0;
   assign unused_bits = ^{32'(CLK_FREQ), startStep, data_in32[31:12], data_in32[5:2]};
`endif

   always_ff @(posedge clk or negedge nres) begin
      if (!nres) begin
         shadow <= '{default: '0};
         dirty  <= '0;
      end else if (srst) begin
         shadow <= '{default: '0};
         dirty  <= '0;
      end else begin
         // later sets override the in-flight clear, so a same-cycle rewrite is not lost
         if (lat) dirty[nxt_ch] <= 1'b0;
         if (step_ok) begin
            shadow[ramp_ch] <= ramp_val;
            dirty[ramp_ch]  <= 1'b1;
         end
         if (ch_wr) begin
            shadow[addr[1:0]] <= data_in32[11:0];
            dirty[addr[1:0]]  <= 1'b1;
         end
         if (ctrl_wr && data_in32[1]) dirty <= 4'hF;
      end
   end

   always_comb begin
      rd_val = '0;
      case (addr)
         ADDR_CH0, ADDR_CH1, ADDR_CH2, ADDR_CH3: rd_val = {20'd0, shadow[addr[1:0]]};
         ADDR_CTRL:   rd_val = {26'd0, ramp_ch, 1'b0, ramp_en, 2'b00};
         ADDR_RAMP:   rd_val = {4'd0, ramp_limit, 4'd0, ramp_step};
         ADDR_STATUS: rd_val = {24'd0, dirty, 2'b00, overrun, busy};
         default:     rd_val = '0;
      endcase
   end

   always_ff @(posedge clk or negedge nres) begin
      if (!nres) data_out32 <= '0;
      else       data_out32 <= rd_val;
   end

   dac7624_tmr #(.W(8)) u_tmr (
      .clk   (clk),
      .nres  (nres),
      .start (tmr_start),
      .load  (tmr_load),
      .done  (tmr_done)
   );

   always_ff @(posedge clk or negedge nres) begin
      if (!nres) begin
         state         <= IDLE;
         nCS           <= 1'b1;
         nLDAC         <= 1'b1;
         nRESET        <= 1'b1;
         ch            <= '0;
         data          <= '0;
         busy          <= 1'b0;
         start_counter <= 1'b0;
         tmr_start     <= 1'b0;
         tmr_load      <= '0;
      end else begin
         tmr_start     <= 1'b0;
         start_counter <= 1'b0;
         if (srst) begin
            state     <= RESET;
            nCS       <= 1'b1;
            nLDAC     <= 1'b1;
            nRESET    <= 1'b0;
            busy      <= 1'b1;
            tmr_start <= 1'b1;
            tmr_load  <= T_RST;
         end else begin
            case (state)
               IDLE: if (lat) begin
                  state     <= SETUP;
                  ch        <= nxt_ch;
                  data      <= shadow[nxt_ch];
                  busy      <= 1'b1;
                  tmr_start <= 1'b1;
                  tmr_load  <= T_SETUP;
               end
               SETUP: if (tmr_done) begin
                  state     <= CS;
                  nCS       <= 1'b0;
                  tmr_start <= 1'b1;
                  tmr_load  <= T_CS;
               end
               CS: if (tmr_done) begin
                  state     <= HOLD;
                  nCS       <= 1'b1;
                  tmr_start <= 1'b1;
                  tmr_load  <= T_HOLD;
               end
               HOLD: if (tmr_done) begin
                  tmr_start <= 1'b1;
                  if (lat) begin
                     state    <= SETUP;
                     ch       <= nxt_ch;
                     data     <= shadow[nxt_ch];
                     tmr_load <= T_SETUP;
                  end else begin
                     state    <= LDAC;
                     nLDAC    <= 1'b0;
                     tmr_load <= T_LDAC;
                  end
               end
               LDAC: if (tmr_done) begin
                  state         <= IDLE;
                  nLDAC         <= 1'b1;
                  busy          <= 1'b0;
                  start_counter <= step_loaded;
               end
               RESET: if (tmr_done) begin
                  state  <= IDLE;
                  nRESET <= 1'b1;
                  busy   <= 1'b0;
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_dac7624_seq.sv
// Scoreboard bench for dac7624_seq: expected pin events are queued with the stimulus and popped by a pin monitor.
`timescale 1ns/1ps
module tb_dac7624_seq;

   localparam logic [7:0] A_CH0 = 8'h10, A_CH1 = 8'h11, A_CH2 = 8'h12, A_CH3 = 8'h13;
   localparam logic [7:0] A_CTRL = 8'h14, A_RAMP = 8'h15, A_STATUS = 8'h16;
   localparam logic [1:0] EV_WR = 2'd0, EV_LDAC = 2'd1, EV_RST = 2'd2, EV_SC = 2'd3;

   typedef struct packed {
      logic [1:0]  kind;
      logic [1:0]  ch;
      logic [11:0] data;
   } ev_t;

   logic        clk = 1'b0, nres = 1'b0, we32 = 1'b0, startStep = 1'b0;
   logic [7:0]  addr = 8'h00;
   logic [31:0] data_in32 = 32'h0;
   logic [31:0] data_out32;
   logic        READ, nCS, nRESET, nLDAC, busy, start_counter;
   logic [1:0]  ch;
   logic [11:0] data;

   ev_t exp_q[$];
   int  errors = 0, checks = 0, cyc = 0;

   dac7624_seq dut (
      .clk(clk), .nres(nres), .we32(we32), .addr(addr), .data_in32(data_in32),
      .data_out32(data_out32), .startStep(startStep), .READ(READ), .nCS(nCS),
      .nRESET(nRESET), .nLDAC(nLDAC), .ch(ch), .data(data), .busy(busy),
      .start_counter(start_counter)
   );

   always #10 clk = ~clk;

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation still running at 1ms, required completion");
      $fatal(1, "watchdog");
   end

   // pin monitor: every falling strobe pops one expected event
   logic       p_ncs = 1'b1, p_ldac = 1'b1, p_nrst = 1'b1, p_sc = 1'b0;
   logic [1:0] p_ch = '0;
   logic [11:0] p_data = '0;
   int cs_w = 0, ld_w = 0, rs_w = 0, cs_rise = 0;

   always @(negedge clk) begin
      ev_t e;
      cyc++;
      if (nres) begin
         if (p_ncs && !nCS) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL dac_write: unexpected write ch=%0d data=%h, required no write", ch, data);
            end else begin
               e = exp_q.pop_front();
               if (e.kind !== EV_WR || ch !== e.ch || data !== e.data || p_ch !== e.ch || p_data !== e.data) begin
                  errors++;
                  $display("FAIL dac_write: got write ch=%0d data=%h (setup ch=%0d data=%h), required event %0d ch=%0d data=%h",
                           ch, data, p_ch, p_data, e.kind, e.ch, e.data);
               end
            end
         end
         if (!nCS) cs_w++;
         if (!p_ncs && nCS) begin
            if (nRESET) begin
               checks++;
               if (cs_w !== 3 || ch !== p_ch || data !== p_data) begin
                  errors++;
                  $display("FAIL ncs_width_hold: low %0d cycles, ch/data %0d/%h after %0d/%h, required 3 cycles and held",
                           cs_w, ch, data, p_ch, p_data);
               end
            end
            cs_w = 0;
            cs_rise = cyc;
         end
         if (p_ldac && !nLDAC) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL ldac: unexpected nLDAC pulse, required none");
            end else begin
               e = exp_q.pop_front();
               if (e.kind !== EV_LDAC || (cyc - cs_rise) !== 1 || nCS !== 1'b1) begin
                  errors++;
                  $display("FAIL ldac: got nLDAC %0d cycles after nCS rose (nCS=%b), required event %0d 1 cycle after",
                           cyc - cs_rise, nCS, e.kind);
               end
            end
         end
         if (!nLDAC) ld_w++;
         if (!p_ldac && nLDAC) begin
            checks++;
            if (ld_w !== 3) begin
               errors++;
               $display("FAIL ldac_width: low %0d cycles, required 3", ld_w);
            end
            ld_w = 0;
         end
         if (p_nrst && !nRESET) begin
            checks++;
            e = (exp_q.size() != 0) ? exp_q.pop_front() : ev_t'(16'hFFFF);
            if (e.kind !== EV_RST) begin
               errors++;
               $display("FAIL nreset: got nRESET pulse, required event %0d", e.kind);
            end
         end
         if (!nRESET) rs_w++;
         if (!p_nrst && nRESET) begin
            checks++;
            if (rs_w !== 5) begin
               errors++;
               $display("FAIL nreset_width: low %0d cycles, required 5", rs_w);
            end
            rs_w = 0;
         end
         if (start_counter) begin
            checks++;
            e = (exp_q.size() != 0 && !p_sc) ? exp_q.pop_front() : ev_t'(16'h0000);
            if (p_sc || e.kind !== EV_SC) begin
               errors++;
               $display("FAIL start_counter: got pulse (previous cycle %b), required event %0d single-cycle", p_sc, e.kind);
            end
         end
      end
      p_ncs = nCS; p_ldac = nLDAC; p_nrst = nRESET; p_sc = start_counter;
      p_ch = ch; p_data = data;
   end

   task automatic push(input logic [1:0] k, input logic [1:0] c, input logic [11:0] d);
      ev_t e;
      e.kind = k; e.ch = c; e.data = d;
      exp_q.push_back(e);
   endtask

   task automatic wr(input logic [7:0] a, input logic [31:0] d);
      we32 = 1'b1; addr = a; data_in32 = d;
      @(negedge clk);
      we32 = 1'b0;
   endtask

   task automatic rd(input logic [7:0] a, output logic [31:0] v);
      addr = a;
      @(negedge clk);
      v = data_out32;
   endtask

   task automatic wait_idle(input string name);
      int n = 0;
      @(negedge clk);
      while ((busy !== 1'b0 || exp_q.size() != 0) && n < 300) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (n >= 300) begin
         errors++;
         $display("FAIL %s_timeout: busy=%b pending=%0d, required busy=0 pending=0", name, busy, exp_q.size());
         exp_q.delete();
      end
      repeat (2) @(negedge clk);
   endtask

   task automatic wait_cs(input string name);
      int n = 0;
      while (nCS !== 1'b0 && n < 100) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (n >= 100) begin
         errors++;
         $display("FAIL %s_cs_timeout: nCS=%b, required 0", name, nCS);
      end
   endtask

   task automatic test_reset();
      logic [31:0] v;
      repeat (3) @(negedge clk);
      checks++;
      if ({nCS, nRESET, nLDAC, READ, ch, data, busy, start_counter} !== {4'b1110, 2'd0, 12'd0, 2'b00}) begin
         errors++;
         $display("FAIL reset_pins: nCS=%b nRESET=%b nLDAC=%b READ=%b ch=%0d data=%h busy=%b sc=%b, required 1 1 1 0 0 000 0 0",
                  nCS, nRESET, nLDAC, READ, ch, data, busy, start_counter);
      end
      nres = 1'b1;
      @(negedge clk);
      rd(A_STATUS, v);
      checks++;
      if (v !== 32'h0) begin errors++; $display("FAIL reset_status: got %h, required 00000000", v); end
      for (int i = 0; i < 4; i++) begin
         rd(A_CH0 + 8'(i), v);
         checks++;
         if (v !== 32'h0) begin errors++; $display("FAIL reset_ch%0d: got %h, required 00000000", i, v); end
      end
   endtask

   task automatic test_single();
      logic [31:0] v;
      push(EV_WR, 2'd2, 12'hABC); push(EV_LDAC, 2'd0, 12'h0);
      wr(A_CH2, 32'hFFFF_FABC);
      wait_idle("single");
      rd(A_CH2, v);
      checks++;
      if (v !== 32'h0000_0ABC) begin errors++; $display("FAIL single_readback: got %h, required 00000abc", v); end
      rd(A_STATUS, v);
      checks++;
      if (v !== 32'h0) begin errors++; $display("FAIL single_status: got %h, required 00000000", v); end
   endtask

   task automatic test_back_to_back();
      logic [31:0] v;
      push(EV_WR, 2'd0, 12'h222); push(EV_WR, 2'd3, 12'h111); push(EV_LDAC, 2'd0, 12'h0);
      wr(A_CH3, 32'h111);
      wr(A_CH0, 32'h222);
      wait_idle("back_to_back");
      rd(A_CH3, v);
      checks++;
      if (v !== 32'h111) begin errors++; $display("FAIL b2b_ch3: got %h, required 00000111", v); end
   endtask

   task automatic test_rewrite_in_flight();
      logic [31:0] v;
      push(EV_WR, 2'd1, 12'h0F0); push(EV_WR, 2'd1, 12'hF0F); push(EV_LDAC, 2'd0, 12'h0);
      wr(A_CH1, 32'h0F0);
      wait_cs("rewrite");
      wr(A_CH1, 32'hF0F);
      wait_idle("rewrite");
      rd(A_CH1, v);
      checks++;
      if (v !== 32'hF0F) begin errors++; $display("FAIL rewrite_ch1: got %h, required 00000f0f", v); end
   endtask

   task automatic test_mark_all();
      push(EV_WR, 2'd0, 12'h222); push(EV_WR, 2'd1, 12'hF0F);
      push(EV_WR, 2'd2, 12'hABC); push(EV_WR, 2'd3, 12'h111); push(EV_LDAC, 2'd0, 12'h0);
      wr(A_CTRL, 32'h2);
      wait_idle("mark_all");
   endtask

   task automatic test_soft_reset();
      logic [31:0] v;
      push(EV_WR, 2'd0, 12'h5A5); push(EV_RST, 2'd0, 12'h0);
      wr(A_CH0, 32'h5A5);
      wr(A_CH2, 32'h333);
      wait_cs("soft_reset");
      wr(A_CTRL, 32'h1);
      checks++;
      if (nCS !== 1'b1 || nRESET !== 1'b0 || busy !== 1'b1) begin
         errors++;
         $display("FAIL soft_reset_abort: nCS=%b nRESET=%b busy=%b, required 1 0 1", nCS, nRESET, busy);
      end
      wait_idle("soft_reset");
      rd(A_STATUS, v);
      checks++;
      if (v !== 32'h0) begin errors++; $display("FAIL soft_reset_status: got %h, required 00000000", v); end
      for (int i = 0; i < 4; i++) begin
         rd(A_CH0 + 8'(i), v);
         checks++;
         if (v !== 32'h0) begin errors++; $display("FAIL soft_reset_ch%0d: got %h, required 00000000", i, v); end
      end
   endtask

`ifdef DAC_RAMP_EN
   task automatic test_ramp();
      logic [31:0] v;
      logic [11:0] model;
      logic [12:0] sum;
      model = 12'h000;
      wr(A_CTRL, 32'h14);
      wr(A_RAMP, 32'h0A00_0400);
      rd(A_CTRL, v);
      checks++;
      if (v !== 32'h14) begin errors++; $display("FAIL ramp_ctrl_read: got %h, required 00000014", v); end
      rd(A_RAMP, v);
      checks++;
      if (v !== 32'h0A00_0400) begin errors++; $display("FAIL ramp_reg_read: got %h, required 0a000400", v); end
      for (int i = 0; i < 4; i++) begin
         sum = {1'b0, model} + 13'h400;
         model = (sum > 13'hA00) ? 12'hA00 : sum[11:0];
         push(EV_WR, 2'd1, model); push(EV_LDAC, 2'd0, 12'h0); push(EV_SC, 2'd0, 12'h0);
         startStep = 1'b1;
         @(negedge clk);
         startStep = 1'b0;
         wait_idle("ramp");
         rd(A_CH1, v);
         checks++;
         if (v !== {20'd0, model}) begin errors++; $display("FAIL ramp_step%0d: got %h, required %h", i, v, model); end
      end
   endtask

   task automatic test_overrun();
      logic [31:0] v;
      push(EV_WR, 2'd1, 12'h100); push(EV_LDAC, 2'd0, 12'h0);
      wr(A_CH1, 32'h100);
      wait_idle("overrun_prep");
      push(EV_WR, 2'd1, 12'h500); push(EV_LDAC, 2'd0, 12'h0); push(EV_SC, 2'd0, 12'h0);
      startStep = 1'b1; @(negedge clk); startStep = 1'b0;
      @(negedge clk);
      startStep = 1'b1; @(negedge clk); startStep = 1'b0;
      wait_idle("overrun");
      rd(A_STATUS, v);
      checks++;
      if (v !== 32'h2) begin errors++; $display("FAIL overrun_set: got status %h, required 00000002", v); end
      rd(A_CH1, v);
      checks++;
      if (v !== 32'h500) begin errors++; $display("FAIL overrun_ch1: got %h, required 00000500", v); end
      wr(A_CTRL, 32'h1C);
      rd(A_STATUS, v);
      checks++;
      if (v !== 32'h0) begin errors++; $display("FAIL overrun_clear: got status %h, required 00000000", v); end
      push(EV_WR, 2'd1, 12'h123); push(EV_LDAC, 2'd0, 12'h0);
      startStep = 1'b1;
      wr(A_CH1, 32'h123);
      startStep = 1'b0;
      wait_idle("clash");
      rd(A_STATUS, v);
      checks++;
      if (v !== 32'h2) begin errors++; $display("FAIL clash_overrun: got status %h, required 00000002", v); end
      rd(A_CH1, v);
      checks++;
      if (v !== 32'h123) begin errors++; $display("FAIL clash_ch1: got %h, required 00000123", v); end
   endtask
`else
   task automatic test_no_ramp();
      logic [31:0] v;
      wr(A_CTRL, 32'h3C);
      wr(A_RAMP, 32'h0A00_0400);
      rd(A_CTRL, v);
      checks++;
      if (v !== 32'h0) begin errors++; $display("FAIL noramp_ctrl_read: got %h, required 00000000", v); end
      rd(A_RAMP, v);
      checks++;
      if (v !== 32'h0) begin errors++; $display("FAIL noramp_ramp_read: got %h, required 00000000", v); end
      startStep = 1'b1; @(negedge clk); startStep = 1'b0;
      repeat (20) @(negedge clk);
      checks++;
      if (busy !== 1'b0 || start_counter !== 1'b0) begin
         errors++;
         $display("FAIL noramp_step: busy=%b start_counter=%b, required 0 0", busy, start_counter);
      end
      rd(A_CH1, v);
      checks++;
      if (v !== 32'h0) begin errors++; $display("FAIL noramp_ch1: got %h, required 00000000", v); end
   endtask
`endif

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_rewrite_in_flight();
      test_mark_all();
      test_soft_reset();
`ifdef DAC_RAMP_EN
      test_ramp();
      test_overrun();
`else
      test_no_ramp();
`endif
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: %0d events pending, required 0", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
